axi_lite_mem_slave: RTL and testbench
=====================================

Name: axi_lite_mem_slave

Overview:
- AXI-Lite-4-style responder (slave) for the 128-bit line interface driven by the instruction and data caches' bus master ports.
- Serves one cache port per instance. Typical use: two instances in the SoC top, one for each cache.
- Contains a byte-strobed line memory with independent read and write channels and a programmable response latency.
- Used as the backing memory in simulation and synthesis.

Parameters:
- DEPTH_LOG2, 12, log2 of line count (4096 lines x 16 B = 64 KB).
- LATENCY, 4, wait cycles between address/data acceptance and response valid; range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- readAddr_addr  input  32  read byte address
- readAddr_valid  input  1  read address valid
- readAddr_ready  output  1  read address accepted
- readData_data  output  128  read line data
- readData_valid  output  1  read data valid
- readData_ready  input  1  master accepts read data
- writeAddr_addr  input  32  write byte address
- writeAddr_valid  input  1  write address valid
- writeAddr_ready  output  1  write address accepted
- writeData_data  input  128  write line data
- writeData_strb  input  16  byte enables, bit i -> bits [8i+7:8i]
- writeData_valid  input  1  write data valid
- writeData_ready  output  1  write data accepted
- writeResp_msg  output  32  0 = OKAY, 3 = DECERR
- writeResp_valid  output  1  write response valid
- writeResp_ready  input  1  master accepts response

Behaviour:
- Reset, asynchronous:
  - Both FSMs go to IDLE; counters = 0.
  - readData_valid = 0, readData_data = 0, writeResp_valid = 0, writeResp_msg = 0.
  - readAddr_ready = 1, writeAddr_ready = 1, writeData_ready = 1.
  - Memory array is not cleared.
  - Reset mid-transaction abandons the transaction. A write not yet committed is lost.
- Addressing:
  - Line index = addr[DEPTH_LOG2+3:4]; addr[3:0] is ignored.
  - An address is out of range if addr[31:DEPTH_LOG2+4] != 0.
- Handshake rule: a transfer occurs on a rising edge where valid && ready. Outputs are registered. Once valid is raised, it and its payload hold until ready.
- Read FSM:
  - R_IDLE: readAddr_ready = 1. On handshake, latch index and range flag, load cnt = LATENCY. Go to R_WAIT, or directly to the data-capture edge if LATENCY = 0.
  - R_WAIT: readAddr_ready = 0; cnt decrements each cycle. On the edge where cnt == 0, capture mem[index] into readData_data (0 if out of range), set readData_valid, go to R_RESP.
  - R_RESP: on readData_ready, clear valid and go to R_IDLE. readAddr_ready returns to 1 the following cycle.
  - Minimum read latency with LATENCY = 0: valid is seen 1 cycle after the address handshake.
- Write FSM:
  - W_IDLE: writeAddr_ready = writeData_ready = 1. Address and data are accepted independently, in either order or in the same cycle; each ready drops once its item is latched.
  - When both are held, load cnt = LATENCY and go to W_WAIT.
  - W_WAIT: on the edge where cnt == 0, commit the write and go to W_RESP:
    - In range: bytes with strb = 1 are written; strb = 0 gives no change.
    - Response: writeResp_valid = 1, msg = 0 (OKAY) in range, 3 (DECERR) out of range with no write.
  - W_RESP: on writeResp_ready, clear valid and go to W_IDLE; both readies return to 1 next cycle.
- Read/write interaction:
  - The channels run concurrently.
  - If a read capture and a write commit to the same line fall on the same edge, the read returns pre-write data.
  - A capture on any later edge sees the new data.
- One outstanding transaction per channel; no ID or reordering.

Test Plan:
1. Reset, then write addr 0x0000_0040, data 0x0011...FF (byte i = 0x11*i mod 256), strb 0xFFFF, LATENCY 4 -> writeResp_valid 5 cycles after the last of addr/data, msg 0. Read 0x0000_0040 -> same 128-bit data, valid 5 cycles after the address handshake.
2. Partial strobe: line 0x40 preloaded as in test 1; write 0xAAAA...AA with strb 0x000F -> readback bytes 0..3 = 0xAA, bytes 4..15 unchanged.
3. Out of range: write to 0x0001_0000 -> msg 3 and no array change. Read from the same address -> readData_data = 0.
4. Backpressure: hold readData_ready = 0 for 6 cycles -> readData_valid and data stable, readAddr_ready = 0 throughout. Release -> transfer, readAddr_ready = 1 next cycle. Same check on writeResp_ready.
5. Write data presented 3 cycles before write address -> writeData_ready drops after data accept, write commits correctly. Same-edge read/write to line 0x80 with LATENCY 0 -> read returns old data.
6. Assert rst during R_WAIT and W_WAIT -> all valids 0 and readies 1 immediately. The pending write is not committed; the line reads back unchanged.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_slave
//
// AXI-Lite style responder that backs one cache bus-master port with a
// byte-strobed memory of 2**DEPTH_LOG2 lines of 128 bits. The read and write
// channels run independently, each with one outstanding transaction and a
// programmable wait of LATENCY cycles before the response is raised.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Every output is registered. A master that raises valid keeps valid and its
// payload stable until it sees ready; this responder keeps readData_valid /
// writeResp_valid and their payloads stable until the master's ready.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   readAddr_*                  read address channel  (addr, valid, ready)
//   readData_*                  read data channel     (data, valid, ready)
//   writeAddr_*                 write address channel (addr, valid, ready)
//   writeData_*                 write data channel    (data, strb, valid, ready)
//   writeResp_*                 write response        (msg 0=OKAY 3=DECERR)
//   dbg_rd_state_o              read FSM state  (R_IDLE/R_WAIT/R_RESP)
//   dbg_wr_state_o              write FSM state (W_IDLE/W_WAIT/W_RESP)
// ---------------------------------------------------------------------------
module axi_lite_mem_slave #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  readAddr_addr,
  input  logic         readAddr_valid,
  output logic         readAddr_ready,
  output logic [127:0] readData_data,
  output logic         readData_valid,
  input  logic         readData_ready,
  input  logic [31:0]  writeAddr_addr,
  input  logic         writeAddr_valid,
  output logic         writeAddr_ready,
  input  logic [127:0] writeData_data,
  input  logic [15:0]  writeData_strb,
  input  logic         writeData_valid,
  output logic         writeData_ready,
  output logic [31:0]  writeResp_msg,
  output logic         writeResp_valid,
  input  logic         writeResp_ready,
  output logic [1:0]   dbg_rd_state_o,
  output logic [1:0]   dbg_wr_state_o
);

  localparam int         LINES  = 1 << DEPTH_LOG2;
  localparam int         IDX_HI = DEPTH_LOG2 + 3;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Line storage; deliberately not reset.
  logic [127:0] mem_q [LINES];

  // The byte offset inside a line never selects anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  logic [1:0]            r_state_q, r_state_d;
  logic [3:0]            r_cnt_q,   r_cnt_d;
  logic [DEPTH_LOG2-1:0] r_idx_q,   r_idx_d;
  logic                  r_oor_q,   r_oor_d;
  logic [127:0]          rdata_q,   rdata_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  arready_q, arready_d;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    r_oor_d   = r_oor_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    arready_d = arready_q;
    case (r_state_q)
      R_IDLE: begin
        if (readAddr_valid && arready_q) begin
          r_idx_d   = readAddr_addr[IDX_HI:4];
          r_oor_d   = |readAddr_addr[31:IDX_HI+1];
          r_cnt_d   = LAT;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // With LATENCY 0 the counter is already zero, so the capture lands on
        // the first edge after the address handshake.
        if (r_cnt_q == 4'd0) begin
          rdata_d   = r_oor_q ? 128'd0 : mem_q[r_idx_q];
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (readData_ready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      r_idx_q   <= '0;
      r_oor_q   <= 1'b0;
      rdata_q   <= 128'd0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_oor_q   <= r_oor_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  logic [1:0]            w_state_q, w_state_d;
  logic [3:0]            w_cnt_q,   w_cnt_d;
  logic [DEPTH_LOG2-1:0] w_idx_q,   w_idx_d;
  logic                  w_oor_q,   w_oor_d;
  logic [127:0]          w_data_q,  w_data_d;
  logic [15:0]           w_strb_q,  w_strb_d;
  logic                  aw_held_q, aw_held_d;
  logic                  wd_held_q, wd_held_d;
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  bvalid_q,  bvalid_d;
  logic [31:0]           bmsg_q,    bmsg_d;
  logic                  aw_hs, wd_hs, wr_commit;

  assign aw_hs = writeAddr_valid && awready_q;
  assign wd_hs = writeData_valid && wready_q;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_idx_d   = w_idx_q;
    w_oor_d   = w_oor_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_held_d = aw_held_q;
    wd_held_d = wd_held_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bmsg_d    = bmsg_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_idx_d   = writeAddr_addr[IDX_HI:4];
          w_oor_d   = |writeAddr_addr[31:IDX_HI+1];
          aw_held_d = 1'b1;
          awready_d = 1'b0;
        end
        if (wd_hs) begin
          w_data_d  = writeData_data;
          w_strb_d  = writeData_strb;
          wd_held_d = 1'b1;
          wready_d  = 1'b0;
        end
        // Start the wait on the edge that latches the second of the pair.
        if ((aw_held_q || aw_hs) && (wd_held_q || wd_hs)) begin
          w_cnt_d   = LAT;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 4'd0) begin
          bvalid_d  = 1'b1;
          bmsg_d    = w_oor_q ? 32'd3 : 32'd0;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (writeResp_ready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          wd_held_d = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        bvalid_d  = 1'b0;
        aw_held_d = 1'b0;
        wd_held_d = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      w_idx_q   <= '0;
      w_oor_q   <= 1'b0;
      w_data_q  <= 128'd0;
      w_strb_q  <= 16'd0;
      aw_held_q <= 1'b0;
      wd_held_q <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bmsg_q    <= 32'd0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_idx_q   <= w_idx_d;
      w_oor_q   <= w_oor_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_held_q <= aw_held_d;
      wd_held_q <= wd_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bmsg_q    <= bmsg_d;
    end
  end

  // The commit edge is the one that raises writeResp_valid. A read capture on
  // that same edge samples mem_q before this update, so it sees old data.
  // Reset forces W_IDLE asynchronously, so an abandoned write never commits.
  assign wr_commit = (w_state_q == W_WAIT) && (w_cnt_q == 4'd0) && !w_oor_q;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 16; b++) begin
        if (w_strb_q[b]) mem_q[w_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign readAddr_ready  = arready_q;
  assign readData_data   = rdata_q;
  assign readData_valid  = rvalid_q;
  assign writeAddr_ready = awready_q;
  assign writeData_ready = wready_q;
  assign writeResp_msg   = bmsg_q;
  assign writeResp_valid = bvalid_q;
  assign dbg_rd_state_o  = r_state_q;
  assign dbg_wr_state_o  = w_state_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mem_slave
//
// Two instances share every input: dut (LATENCY 4) and dut_l0 (LATENCY 0).
// Both accept requests on the same edges; the LATENCY 0 copy simply responds
// earlier and holds its response until the shared ready. Inputs are driven
// and outputs sampled on the falling edge; the rising edge is active.
// ---------------------------------------------------------------------------
module tb_axi_lite_mem_slave;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  readAddr_addr;
  logic         readAddr_valid;
  logic         readData_ready;
  logic [31:0]  writeAddr_addr;
  logic         writeAddr_valid;
  logic [127:0] writeData_data;
  logic [15:0]  writeData_strb;
  logic         writeData_valid;
  logic         writeResp_ready;

  logic         readAddr_ready,  z_readAddr_ready;
  logic [127:0] readData_data,   z_readData_data;
  logic         readData_valid,  z_readData_valid;
  logic         writeAddr_ready, z_writeAddr_ready;
  logic         writeData_ready, z_writeData_ready;
  logic [31:0]  writeResp_msg,   z_writeResp_msg;
  logic         writeResp_valid, z_writeResp_valid;
  logic [1:0]   dbg_rd_state,    z_dbg_rd_state;
  logic [1:0]   dbg_wr_state,    z_dbg_wr_state;

  axi_lite_mem_slave #(.DEPTH_LOG2(12), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
    .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
    .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb), .writeData_valid(writeData_valid),
    .writeData_ready(writeData_ready),
    .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready),
    .dbg_rd_state_o(dbg_rd_state), .dbg_wr_state_o(dbg_wr_state)
  );

  axi_lite_mem_slave #(.DEPTH_LOG2(12), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst),
    .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(z_readAddr_ready),
    .readData_data(z_readData_data), .readData_valid(z_readData_valid), .readData_ready(readData_ready),
    .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(z_writeAddr_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb), .writeData_valid(writeData_valid),
    .writeData_ready(z_writeData_ready),
    .writeResp_msg(z_writeResp_msg), .writeResp_valid(z_writeResp_valid), .writeResp_ready(writeResp_ready),
    .dbg_rd_state_o(z_dbg_rd_state), .dbg_wr_state_o(z_dbg_wr_state)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] PAT  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] PAT2 = 128'hFFEEDDCCBBAA998877665544AAAAAAAA;

  // ---------------------------------------------------------------------------
  // driver tasks (no checking inside)
  // ---------------------------------------------------------------------------
  // lat = falling edges after the handshake edge until resp valid is seen.
  task automatic axi_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                           output logic [31:0] msg, output int lat);
    int n;
    logic aw_done, w_done;
    @(negedge clk);
    writeAddr_addr = a; writeAddr_valid = 1'b1;
    writeData_data = d; writeData_strb = s; writeData_valid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      if (writeAddr_ready) aw_done = 1'b1;
      if (writeData_ready) w_done = 1'b1;
      @(negedge clk);
      if (aw_done) writeAddr_valid = 1'b0;
      if (w_done)  writeData_valid = 1'b0;
      n++;
    end
    writeAddr_valid = 1'b0; writeData_valid = 1'b0;
    lat = 0;
    while (!writeResp_valid && lat < 40) begin @(negedge clk); lat++; end
    msg = writeResp_msg;
    writeResp_ready = 1'b1;
    @(negedge clk);
    writeResp_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [127:0] d, output int lat);
    int n;
    @(negedge clk);
    readAddr_addr = a; readAddr_valid = 1'b1;
    n = 0;
    while (!readAddr_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    readAddr_valid = 1'b0;
    lat = 0;
    while (!readData_valid && lat < 40) begin @(negedge clk); lat++; end
    d = readData_data;
    readData_ready = 1'b1;
    @(negedge clk);
    readData_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // test tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // while reset is held
    total++;
    if ({readData_valid, writeResp_valid, readAddr_ready, writeAddr_ready, writeData_ready} !== 5'b00111) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00111",
        {readData_valid, writeResp_valid, readAddr_ready, writeAddr_ready, writeData_ready});
    end
    total++;
    if (readData_data !== 128'd0 || writeResp_msg !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", readData_data, writeResp_msg);
    end
    total++;
    if ({dbg_rd_state, dbg_wr_state} !== 4'b0000) begin
      bad++; $display("FAIL reset_state got=%b exp=0000", {dbg_rd_state, dbg_wr_state});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({readData_valid, writeResp_valid, readAddr_ready, writeAddr_ready, writeData_ready} !== 5'b00111) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=00111",
        {readData_valid, writeResp_valid, readAddr_ready, writeAddr_ready, writeData_ready});
    end
  endtask

  task automatic test_basic();
    logic [31:0] msg; logic [127:0] d; int lat;
    axi_write(32'h0000_0040, PAT, 16'hFFFF, msg, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL basic_wr_lat got=%0d exp=5", lat); end
    total++; if (msg !== 32'd0) begin bad++; $display("FAIL basic_wr_msg got=%0d exp=0", msg); end
    axi_read(32'h0000_0040, d, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL basic_rd_lat got=%0d exp=5", lat); end
    total++; if (d !== PAT) begin bad++; $display("FAIL basic_rd_data got=%h exp=%h", d, PAT); end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] msg; logic [127:0] d; int lat;
    axi_write(32'h0000_0040, {16{8'hAA}}, 16'h000F, msg, lat);
    total++; if (msg !== 32'd0) begin bad++; $display("FAIL partial_msg got=%0d exp=0", msg); end
    axi_read(32'h0000_0040, d, lat);
    total++; if (d !== PAT2) begin bad++; $display("FAIL partial_data got=%h exp=%h", d, PAT2); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] msg; logic [127:0] d; int lat;
    logic [127:0] c0;
    c0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    axi_write(32'h0000_0000, c0, 16'hFFFF, msg, lat);
    axi_write(32'h0001_0000, {16{8'h55}}, 16'hFFFF, msg, lat);
    total++; if (msg !== 32'd3) begin bad++; $display("FAIL oor_wr_msg got=%0d exp=3", msg); end
    total++; if (lat !== 5) begin bad++; $display("FAIL oor_wr_lat got=%0d exp=5", lat); end
    axi_read(32'h0001_0000, d, lat);
    total++; if (d !== 128'd0) begin bad++; $display("FAIL oor_rd_data got=%h exp=0", d); end
    // line 0 aliases the low index bits of 0x1_0000 and must be untouched
    axi_read(32'h0000_0000, d, lat);
    total++; if (d !== c0) begin bad++; $display("FAIL oor_no_alias got=%h exp=%h", d, c0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] msg; logic [127:0] d; int lat; int n;
    logic [127:0] wd;
    // read side: line 0x40 holds PAT2
    @(negedge clk);
    readAddr_addr = 32'h0000_0040; readAddr_valid = 1'b1;
    @(negedge clk);
    readAddr_valid = 1'b0;
    n = 0;
    while (!readData_valid && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (readData_valid !== 1'b1 || readData_data !== PAT2 || readAddr_ready !== 1'b0) begin
        bad++; $display("FAIL rd_hold[%0d] got=v%b r%b %h exp=v1 r0 %h",
          i, readData_valid, readAddr_ready, readData_data, PAT2);
      end
      @(negedge clk);
    end
    readData_ready = 1'b1;
    @(negedge clk);
    readData_ready = 1'b0;
    total++;
    if (readData_valid !== 1'b0 || readAddr_ready !== 1'b1) begin
      bad++; $display("FAIL rd_release got=v%b r%b exp=v0 r1", readData_valid, readAddr_ready);
    end
    // write side
    wd = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    @(negedge clk);
    writeAddr_addr = 32'h0000_0050; writeAddr_valid = 1'b1;
    writeData_data = wd; writeData_strb = 16'hFFFF; writeData_valid = 1'b1;
    @(negedge clk);
    writeAddr_valid = 1'b0; writeData_valid = 1'b0;
    n = 0;
    while (!writeResp_valid && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (writeResp_valid !== 1'b1 || writeResp_msg !== 32'd0 ||
          writeAddr_ready !== 1'b0 || writeData_ready !== 1'b0) begin
        bad++; $display("FAIL wr_hold[%0d] got=v%b m%0d ar%b dr%b exp=v1 m0 ar0 dr0",
          i, writeResp_valid, writeResp_msg, writeAddr_ready, writeData_ready);
      end
      @(negedge clk);
    end
    writeResp_ready = 1'b1;
    @(negedge clk);
    writeResp_ready = 1'b0;
    total++;
    if ({writeResp_valid, writeAddr_ready, writeData_ready} !== 3'b011) begin
      bad++; $display("FAIL wr_release got=%b exp=011", {writeResp_valid, writeAddr_ready, writeData_ready});
    end
    axi_read(32'h0000_0050, d, lat);
    total++; if (d !== wd) begin bad++; $display("FAIL bp_wr_data got=%h exp=%h", d, wd); end
  endtask

  task automatic test_data_before_addr();
    logic [127:0] d; int lat;
    logic [127:0] wd;
    wd = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    @(negedge clk);
    writeData_data = wd; writeData_strb = 16'hFFFF; writeData_valid = 1'b1;
    writeAddr_addr = 32'h0000_0060;
    @(negedge clk);
    writeData_valid = 1'b0;
    total++;
    if ({writeData_ready, writeAddr_ready} !== 2'b01) begin
      bad++; $display("FAIL dfirst_readies got=%b exp=01", {writeData_ready, writeAddr_ready});
    end
    repeat (2) @(negedge clk);
    total++;
    if (writeResp_valid !== 1'b0 || dbg_wr_state !== 2'd0) begin
      bad++; $display("FAIL dfirst_waits got=v%b s%0d exp=v0 s0", writeResp_valid, dbg_wr_state);
    end
    writeAddr_valid = 1'b1;
    @(negedge clk);
    writeAddr_valid = 1'b0;
    lat = 0;
    while (!writeResp_valid && lat < 40) begin @(negedge clk); lat++; end
    total++; if (lat !== 5) begin bad++; $display("FAIL dfirst_lat got=%0d exp=5", lat); end
    total++; if (writeResp_msg !== 32'd0) begin bad++; $display("FAIL dfirst_msg got=%0d exp=0", writeResp_msg); end
    writeResp_ready = 1'b1;
    @(negedge clk);
    writeResp_ready = 1'b0;
    axi_read(32'h0000_0060, d, lat);
    total++; if (d !== wd) begin bad++; $display("FAIL dfirst_data got=%h exp=%h", d, wd); end
  endtask

  task automatic test_same_edge();
    logic [31:0] msg; logic [127:0] d; int lat;
    logic [127:0] old_v, new_v;
    old_v = 128'h11112222333344445555666677778888;
    new_v = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;
    axi_write(32'h0000_0800, old_v, 16'hFFFF, msg, lat);
    // address, data and read address all handshake on one edge
    @(negedge clk);
    writeAddr_addr = 32'h0000_0800; writeAddr_valid = 1'b1;
    writeData_data = new_v; writeData_strb = 16'hFFFF; writeData_valid = 1'b1;
    readAddr_addr = 32'h0000_0800; readAddr_valid = 1'b1;
    @(negedge clk);
    writeAddr_valid = 1'b0; writeData_valid = 1'b0; readAddr_valid = 1'b0;
    total++;
    if (z_readData_valid !== 1'b0) begin bad++; $display("FAIL l0_early got=%b exp=0", z_readData_valid); end
    @(negedge clk);
    total++;
    if (z_readData_valid !== 1'b1 || z_writeResp_valid !== 1'b1) begin
      bad++; $display("FAIL l0_lat got=r%b w%b exp=r1 w1", z_readData_valid, z_writeResp_valid);
    end
    total++;
    if (z_readData_data !== old_v) begin bad++; $display("FAIL l0_same_edge got=%h exp=%h", z_readData_data, old_v); end
    repeat (4) @(negedge clk);
    total++;
    if (readData_valid !== 1'b1 || readData_data !== old_v) begin
      bad++; $display("FAIL l4_same_edge got=v%b %h exp=v1 %h", readData_valid, readData_data, old_v);
    end
    readData_ready = 1'b1; writeResp_ready = 1'b1;
    @(negedge clk);
    readData_ready = 1'b0; writeResp_ready = 1'b0;
    axi_read(32'h0000_0800, d, lat);
    total++; if (d !== new_v) begin bad++; $display("FAIL same_edge_after got=%h exp=%h", d, new_v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] msg; logic [127:0] d; int lat;
    logic [127:0] keep_v;
    keep_v = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    axi_write(32'h0000_0300, keep_v, 16'hFFFF, msg, lat);
    @(negedge clk);
    writeAddr_addr = 32'h0000_0300; writeAddr_valid = 1'b1;
    writeData_data = {16{8'h77}}; writeData_strb = 16'hFFFF; writeData_valid = 1'b1;
    readAddr_addr = 32'h0000_0040; readAddr_valid = 1'b1;
    @(negedge clk);
    writeAddr_valid = 1'b0; writeData_valid = 1'b0; readAddr_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({dbg_rd_state, dbg_wr_state} !== 4'b0101) begin
      bad++; $display("FAIL mid_in_wait got=%b exp=0101", {dbg_rd_state, dbg_wr_state});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({readData_valid, writeResp_valid, readAddr_ready, writeAddr_ready, writeData_ready} !== 5'b00111) begin
      bad++; $display("FAIL mid_reset got=%b exp=00111",
        {readData_valid, writeResp_valid, readAddr_ready, writeAddr_ready, writeData_ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (readData_valid !== 1'b0 || writeResp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_stays_idle got=r%b w%b exp=r0 w0", readData_valid, writeResp_valid);
    end
    axi_read(32'h0000_0300, d, lat);
    total++; if (d !== keep_v) begin bad++; $display("FAIL mid_no_commit got=%h exp=%h", d, keep_v); end
  endtask

  // ---------------------------------------------------------------------------
  // sequence + report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    readAddr_addr = 32'd0; readAddr_valid = 1'b0; readData_ready = 1'b0;
    writeAddr_addr = 32'd0; writeAddr_valid = 1'b0;
    writeData_data = 128'd0; writeData_strb = 16'd0; writeData_valid = 1'b0;
    writeResp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_data_before_addr();
    test_same_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
